uart_cmd_parser: RTL and testbench

- Upstream command-framing stage between the host UART receiver and the SD control FSM.
- Consumes received UART bytes, locates and validates fixed-length host command frames, and presents each frame to the FSM:
  - host opcode (host_cmd)
  - SD command index (uart_cmd)
  - 32-bit argument
- Presentation uses a valid/ready handshake.
- Malformed, corrupted, stalled or overrun frames are dropped and reported with an error code.

---
 rtl/uart_cmd_parser.sv | 144 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Frames host command bytes from the UART receiver into opcode/index/argument
// commands for the SD control FSM, with checksum, format, timeout and overrun checks.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         CNT_W          = 17
) (
    input  logic        ex_clk,
    input  logic        ex_resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [3:0]  host_cmd,
    output logic [5:0]  uart_cmd,
    output logic [31:0] cmd_arg,
    output logic        err_pulse,
    output logic [2:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_IDX,
        ST_ARG,
        ST_CSUM
    } state_t;

    localparam logic [2:0] ERR_FORMAT   = 3'd1;
    localparam logic [2:0] ERR_CHECKSUM = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_OVERRUN  = 3'd4;

    // The silent cycle that would bring the counter to TIMEOUT_CYCLES is the one that expires.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  idle_cnt;
    logic [1:0]        byte_cnt;
    logic [7:0]        csum;
    logic [3:0]        shadow_opc;
    logic [5:0]        shadow_idx;
    logic [31:0]       shadow_arg;

    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            state      <= ST_IDLE;
            idle_cnt   <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            shadow_opc <= '0;
            shadow_idx <= '0;
            shadow_arg <= '0;
            cmd_valid  <= 1'b0;
            host_cmd   <= '0;
            uart_cmd   <= '0;
            cmd_arg    <= '0;
            err_pulse  <= 1'b0;
            err_code   <= '0;
            busy       <= 1'b0;
        end else begin
            err_pulse <= 1'b0;

            if (cmd_valid && cmd_ready)
                cmd_valid <= 1'b0;

            if (state == ST_IDLE || rx_valid)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (state == ST_IDLE) begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state <= ST_OPC;
                    busy  <= 1'b1;
                    csum  <= '0;
                end
            end else if (rx_valid) begin
                case (state)
                    ST_OPC: begin
                        if (rx_data[7:4] != 4'd0) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_FORMAT;
                        end else begin
                            shadow_opc <= rx_data[3:0];
                            csum       <= csum ^ rx_data;
                            state      <= ST_IDX;
                        end
                    end
                    ST_IDX: begin
                        if (rx_data[7:6] != 2'd0) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            err_pulse <= 1'b1;
                            err_code  <= ERR_FORMAT;
                        end else begin
                            shadow_idx <= rx_data[5:0];
                            csum       <= csum ^ rx_data;
                            byte_cnt   <= '0;
                            state      <= ST_ARG;
                        end
                    end
                    ST_ARG: begin
                        shadow_arg <= {shadow_arg[23:0], rx_data};
                        csum       <= csum ^ rx_data;
                        byte_cnt   <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3)
                            state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (rx_data != csum) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_CHECKSUM;
                        end else if (!cmd_valid || cmd_ready) begin
                            // A same-cycle transfer frees the output slot for this frame.
                            host_cmd  <= shadow_opc;
                            uart_cmd  <= shadow_idx;
                            cmd_arg   <= shadow_arg;
                            cmd_valid <= 1'b1;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_OVERRUN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (idle_cnt == TO_LAST) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                err_pulse <= 1'b1;
                err_code  <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: nominal, checksum, format, timeout,
// overrun and asynchronous-reset scenarios with hand-computed expectations.
module tb_uart_cmd_parser;

    logic        ex_clk = 1'b0;
    logic        ex_resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  host_cmd;
    logic [5:0]  uart_cmd;
    logic [31:0] cmd_arg;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic        busy;

    int total = 0;
    int bad   = 0;

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (17)
    ) dut (
        .ex_clk    (ex_clk),
        .ex_resetn (ex_resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .host_cmd  (host_cmd),
        .uart_cmd  (uart_cmd),
        .cmd_arg   (cmd_arg),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 ex_clk = ~ex_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; presents one byte for exactly one cycle and returns at the next negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge ex_clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [7:0] idx,
                              input logic [31:0] arg, input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(opc);
        send_byte(idx);
        send_byte(arg[31:24]);
        send_byte(arg[23:16]);
        send_byte(arg[15:8]);
        send_byte(arg[7:0]);
        send_byte(cs);
    endtask

    task automatic pulse_ready();
        cmd_ready = 1'b1;
        @(negedge ex_clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        ex_resetn = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_host_cmd",  32'(host_cmd),  32'd0);
        check("rst_uart_cmd",  32'(uart_cmd),  32'd0);
        check("rst_cmd_arg",   cmd_arg,        32'd0);
        check("rst_err",       {28'd0, err_pulse, err_code}, 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        repeat (2) @(negedge ex_clk);
        ex_resetn = 1'b1;
        @(negedge ex_clk);

        // Nominal frame, output held while cmd_ready is low
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        check("t1_busy_mid",      32'(busy),      32'd1);
        check("t1_valid_pre",     32'(cmd_valid), 32'd0);
        send_byte(8'h1A);
        check("t1_valid",         32'(cmd_valid), 32'd1);
        check("t1_host_cmd",      32'(host_cmd),  32'd3);
        check("t1_uart_cmd",      32'(uart_cmd),  32'h11);
        check("t1_cmd_arg",       cmd_arg,        32'h12345678);
        check("t1_err_pulse",     32'(err_pulse), 32'd0);
        check("t1_busy_after",    32'(busy),      32'd0);
        @(negedge ex_clk);
        check("t1_valid_held",    32'(cmd_valid), 32'd1);
        pulse_ready();
        check("t1_valid_cleared", 32'(cmd_valid), 32'd0);
        check("t1_host_kept",     32'(host_cmd),  32'd3);
        check("t1_arg_kept",      cmd_arg,        32'h12345678);

        // Checksum error
        send_frame(8'h03, 8'h11, 32'h12345678, 8'h1B);
        check("t2_valid",     32'(cmd_valid), 32'd0);
        check("t2_err_pulse", 32'(err_pulse), 32'd1);
        check("t2_err_code",  32'(err_code),  32'd2);
        check("t2_busy",      32'(busy),      32'd0);
        @(negedge ex_clk);
        check("t2_pulse_one", 32'(err_pulse), 32'd0);
        check("t2_code_held", 32'(err_code),  32'd2);

        // Garbage ignored, then format error on opcode
        send_byte(8'h00); send_byte(8'hFF);
        check("t3_garbage_busy",  32'(busy),      32'd0);
        check("t3_garbage_pulse", 32'(err_pulse), 32'd0);
        send_byte(8'hA5); send_byte(8'h13);
        check("t3_err_pulse", 32'(err_pulse), 32'd1);
        check("t3_err_code",  32'(err_code),  32'd1);
        check("t3_busy",      32'(busy),      32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
        check("t3_idx_err_code", 32'(err_code), 32'd1);
        check("t3_idx_pulse",    32'(err_pulse), 32'd1);
        send_frame(8'h03, 8'h11, 32'h12345678, 8'h1A);
        check("t3_recover_valid", 32'(cmd_valid), 32'd1);
        check("t3_recover_host",  32'(host_cmd),  32'd3);
        pulse_ready();

        // Timeout after sixteen silent cycles
        send_byte(8'hA5); send_byte(8'h03);
        repeat (15) @(negedge ex_clk);
        check("t4_no_timeout_yet", 32'(err_pulse), 32'd0);
        check("t4_busy_waiting",   32'(busy),      32'd1);
        @(negedge ex_clk);
        check("t4_to_pulse", 32'(err_pulse), 32'd1);
        check("t4_to_code",  32'(err_code),  32'd3);
        check("t4_to_busy",  32'(busy),      32'd0);

        // A byte on the sixteenth cycle wins over the timeout
        send_byte(8'hA5); send_byte(8'h03);
        repeat (15) @(negedge ex_clk);
        send_byte(8'h11);
        check("t4_edge_pulse", 32'(err_pulse), 32'd0);
        check("t4_edge_busy",  32'(busy),      32'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h1A);
        check("t4_edge_valid", 32'(cmd_valid), 32'd1);
        check("t4_edge_arg",   cmd_arg,        32'h12345678);
        check("t4_edge_code",  32'(err_code),  32'd3);

        // Overrun: held command is not replaced
        send_frame(8'h01, 8'h00, 32'h00000000, 8'h01);
        check("t5_ovr_pulse", 32'(err_pulse), 32'd1);
        check("t5_ovr_code",  32'(err_code),  32'd4);
        check("t5_ovr_valid", 32'(cmd_valid), 32'd1);
        check("t5_ovr_host",  32'(host_cmd),  32'd3);
        check("t5_ovr_uart",  32'(uart_cmd),  32'h11);
        check("t5_ovr_arg",   cmd_arg,        32'h12345678);

        // Same frame with a transfer on the commit cycle replaces the command
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        cmd_ready = 1'b1;
        send_byte(8'h01);
        cmd_ready = 1'b0;
        check("t5_swap_valid", 32'(cmd_valid), 32'd1);
        check("t5_swap_host",  32'(host_cmd),  32'd1);
        check("t5_swap_uart",  32'(uart_cmd),  32'd0);
        check("t5_swap_arg",   cmd_arg,        32'd0);
        check("t5_swap_pulse", 32'(err_pulse), 32'd0);

        // Asynchronous reset mid-frame while a command is held
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        check("t6_pre_busy",  32'(busy),      32'd1);
        check("t6_pre_valid", 32'(cmd_valid), 32'd1);
        #2;
        ex_resetn = 1'b0;
        #1;
        check("t6_rst_valid", 32'(cmd_valid), 32'd0);
        check("t6_rst_host",  32'(host_cmd),  32'd0);
        check("t6_rst_code",  32'(err_code),  32'd0);
        check("t6_rst_busy",  32'(busy),      32'd0);
        @(negedge ex_clk);
        ex_resetn = 1'b1;
        @(negedge ex_clk);
        send_frame(8'h03, 8'h11, 32'h12345678, 8'h1A);
        check("t6_post_valid", 32'(cmd_valid), 32'd1);
        check("t6_post_host",  32'(host_cmd),  32'd3);
        check("t6_post_uart",  32'(uart_cmd),  32'h11);
        check("t6_post_arg",   cmd_arg,        32'h12345678);
        check("t6_post_code",  32'(err_code),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
